time_display_scan: RTL and testbench

//  Consumer of the 12-hour BCD time bus {pm, hh, mm, ss}. Drives a 6-digit

---
 rtl/time_disp_pkg.sv | 44 ++++
 rtl/bcd_to_7seg.sv | 31 +++
 rtl/time_display_scan.sv | 142 ++++++++++++++
 tb/tb_time_display_scan.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/time_disp_pkg.sv
// Shared definitions for the multiplexed time display: digit slots, 7-segment
// glyphs ({g,f,e,d,c,b,a}, active-high) and the time shown after reset.
package time_disp_pkg;

  typedef enum logic [2:0] {
    DIG_SS1  = 3'd0,
    DIG_SS10 = 3'd1,
    DIG_MM1  = 3'd2,
    DIG_MM10 = 3'd3,
    DIG_HH1  = 3'd4,
    DIG_HH10 = 3'd5
  } digit_t;

  typedef struct packed {
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } time_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [7:0] RST_HH = 8'h12;
  localparam logic [7:0] RST_MM = 8'h00;
  localparam logic [7:0] RST_SS = 8'h00;

  // Scan order runs from seconds-ones up to hours-tens, then wraps.
  function automatic digit_t next_digit(input digit_t d);
    if (d == DIG_HH10) return DIG_SS1;
    return digit_t'(d + 3'd1);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show a
// dash and raise invalid.
module bcd_to_7seg
  import time_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg,
  output logic       invalid
);

  always_comb begin
    invalid = 1'b0;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: begin
        seg     = SEG_DASH;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// Scans a 6-digit HH MM SS display from a per-frame shadow of the BCD time bus.
// Define HOUR_BLANK_EN to blank a leading zero in the hours-tens digit.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start,
  output logic       bcd_err
);

  localparam int            CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYC);
  localparam logic          POL     = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_t        digit_q, digit_d;
  time_t         shadow_q, shadow_d;
  logic          framed_q, framed_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;
  logic          fs_q, fs_d;
  logic          err_q, err_d;

  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          dec_inv;
  logic [6:0]    glyph;
  logic          slot_tick;
  logic          active;
  logic [6:0]    seg_raw;
  logic [5:0]    an_raw;
  logic          dp_raw;

  always_comb begin
    case (digit_q)
      DIG_SS1:  nibble = shadow_q.ss[3:0];
      DIG_SS10: nibble = shadow_q.ss[7:4];
      DIG_MM1:  nibble = shadow_q.mm[3:0];
      DIG_MM10: nibble = shadow_q.mm[7:4];
      DIG_HH1:  nibble = shadow_q.hh[3:0];
      default:  nibble = shadow_q.hh[7:4];
    endcase
  end

  bcd_to_7seg u_dec (
    .nibble  (nibble),
    .seg     (dec_seg),
    .invalid (dec_inv)
  );

  always_comb begin
`ifdef HOUR_BLANK_EN
    glyph = ((digit_q == DIG_HH10) && (nibble == 4'd0)) ? SEG_BLANK : dec_seg;
`else
    glyph = dec_seg;
`endif
  end

  // The shadow only reloads as the scan wraps to digit 0, so a frame never tears.
  always_comb begin
    slot_tick = (cnt_q == CNT_MAX);
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    shadow_d  = shadow_q;
    framed_d  = framed_q;
    if (en) begin
      cnt_d = slot_tick ? '0 : cnt_q + CW'(1);
      if (slot_tick) begin
        digit_d = next_digit(digit_q);
        if (digit_q == DIG_HH10) begin
          shadow_d = time_t'({pm, hh, mm, ss});
          framed_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    active  = en && (cnt_q >= DEAD);
    an_raw  = '0;
    seg_raw = SEG_BLANK;
    dp_raw  = 1'b0;
    if (active) begin
      an_raw  = 6'b000001 << digit_q;
      seg_raw = glyph;
      dp_raw  = (digit_q == DIG_MM1) || (digit_q == DIG_HH1) ||
                ((digit_q == DIG_SS1) && shadow_q.pm);
    end
    // Pin polarity is folded in only here, right before the output flops.
    seg_d = seg_raw ^ {7{POL}};
    an_d  = an_raw ^ {6{POL}};
    dp_d  = dp_raw ^ POL;
    fs_d  = en && framed_q && (cnt_q == '0) && (digit_q == DIG_SS1);
    err_d = err_q | (en & dec_inv);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      digit_q  <= DIG_SS1;
      shadow_q <= time_t'({1'b0, RST_HH, RST_MM, RST_SS});
      framed_q <= 1'b0;
      seg_q    <= {7{POL}};
      an_q     <= {6{POL}};
      dp_q     <= POL;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      framed_q <= framed_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
      err_q    <= err_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;
  assign bcd_err     = err_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with SCAN_DIV=8, DEAD_CYC=2, active-high pins;
// every output cycle of each scanned frame is compared against hand-derived glyphs.
module tb_time_display_scan;

  localparam int SCAN_DIV = 8;
  localparam int DEAD_CYC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] hh, mm, ss;
  logic       pm;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_start;
  logic       bcd_err;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_glyph [6];
  logic       exp_dp    [6];

  time_display_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEAD_CYC       (DEAD_CYC),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .hh          (hh),
    .mm          (mm),
    .ss          (ss),
    .pm          (pm),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start),
    .bcd_err     (bcd_err)
  );

  always #5 clk = ~clk;

  // 0-9 decimal glyphs, 10 = blank, 11 = dash; bits {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input int n);
    case (n)
      0:       return 7'b0111111;
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      7:       return 7'b0000111;
      8:       return 7'b1111111;
      9:       return 7'b1101111;
      11:      return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                               input logic p, input logic e);
    hh = h;
    mm = m;
    ss = s;
    pm = p;
    en = e;
  endtask

  task automatic setFrame(input int d0, input int d1, input int d2, input int d3,
                          input int d4, input int d5, input logic pm_dp);
    exp_glyph[0] = glyph(d0);
    exp_glyph[1] = glyph(d1);
    exp_glyph[2] = glyph(d2);
    exp_glyph[3] = glyph(d3);
    exp_glyph[4] = glyph(d4);
    exp_glyph[5] = glyph(d5);
    exp_dp[0] = pm_dp;
    exp_dp[1] = 1'b0;
    exp_dp[2] = 1'b1;
    exp_dp[3] = 1'b0;
    exp_dp[4] = 1'b1;
    exp_dp[5] = 1'b0;
  endtask

  // Output cycle k of a frame: slot k/8, position k%8 within the slot.
  task automatic runSlots(input string phase, input int first, input int last, input logic fs_expected);
    int         p;
    int         d;
    logic [5:0] exp_an;
    for (int k = first; k <= last; k++) begin
      @(posedge clk);
      @(negedge clk);
      p = k % SCAN_DIV;
      d = k / SCAN_DIV;
      exp_an = (p < DEAD_CYC) ? 6'd0 : 6'(1 << d);
      checkOutput($sformatf("%s an k%0d", phase, k), 32'(an), 32'(exp_an));
      if (p >= DEAD_CYC) begin
        checkOutput($sformatf("%s seg k%0d", phase, k), 32'(seg), 32'(exp_glyph[d]));
        checkOutput($sformatf("%s dp k%0d", phase, k), 32'(dp), 32'(exp_dp[d]));
      end
      checkOutput($sformatf("%s frame_start k%0d", phase, k), 32'(frame_start),
                  32'((k == 0) && fs_expected));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(8'h12, 8'h34, 8'h56, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset an", 32'(an), 32'd0);
    checkOutput("reset seg", 32'(seg), 32'd0);
    checkOutput("reset dp", 32'(dp), 32'd0);
    checkOutput("reset frame_start", 32'(frame_start), 32'd0);
    checkOutput("reset bcd_err", 32'(bcd_err), 32'd0);
    reset_n = 1'b1;

    $display("[TB] first frame shows reset time 12:00:00 AM");
    setFrame(0, 0, 0, 0, 2, 1, 1'b0);
    runSlots("f1", 0, 47, 1'b0);

    setFrame(6, 5, 4, 3, 2, 1, 1'b1);
    runSlots("f2", 0, 47, 1'b1);

    $display("[TB] ss changes mid-frame");
    runSlots("f3a", 0, 27, 1'b1);
    ss = 8'h57;
    runSlots("f3b", 28, 47, 1'b0);
    setFrame(7, 5, 4, 3, 2, 1, 1'b1);
    runSlots("f4", 0, 47, 1'b1);

    $display("[TB] invalid BCD on seconds");
    ss = 8'h5A;
    runSlots("f5", 0, 47, 1'b1);
    checkOutput("bcd_err before bad frame", 32'(bcd_err), 32'd0);
    setFrame(11, 5, 4, 3, 2, 1, 1'b1);
    runSlots("f6a", 0, 23, 1'b1);
    checkOutput("bcd_err on dash", 32'(bcd_err), 32'd1);
    ss = 8'h59;
    runSlots("f6b", 24, 47, 1'b0);
    setFrame(9, 5, 4, 3, 2, 1, 1'b1);
    runSlots("f7", 0, 47, 1'b1);
    checkOutput("bcd_err sticky", 32'(bcd_err), 32'd1);

    $display("[TB] enable pause mid-slot");
    runSlots("f8a", 0, 29, 1'b1);
    en = 1'b0;
    hh = 8'h09;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("pause an c%0d", i), 32'(an), 32'd0);
      checkOutput($sformatf("pause seg c%0d", i), 32'(seg), 32'd0);
      checkOutput($sformatf("pause dp c%0d", i), 32'(dp), 32'd0);
      checkOutput($sformatf("pause frame_start c%0d", i), 32'(frame_start), 32'd0);
    end
    en = 1'b1;
    runSlots("f8b", 30, 47, 1'b0);

    $display("[TB] hours 09");
`ifdef HOUR_BLANK_EN
    setFrame(9, 5, 4, 3, 9, 10, 1'b1);
`else
    setFrame(9, 5, 4, 3, 9, 0, 1'b1);
`endif
    runSlots("f9", 0, 47, 1'b1);
    checkOutput("bcd_err still sticky", 32'(bcd_err), 32'd1);

    $display("[TB] async reset mid-slot");
    runSlots("f10", 0, 20, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset an", 32'(an), 32'd0);
    checkOutput("async reset seg", 32'(seg), 32'd0);
    checkOutput("async reset dp", 32'(dp), 32'd0);
    checkOutput("async reset frame_start", 32'(frame_start), 32'd0);
    checkOutput("async reset bcd_err", 32'(bcd_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    setFrame(0, 0, 0, 0, 2, 1, 1'b0);
    runSlots("post_reset", 0, 47, 1'b0);
    checkOutput("bcd_err after reset", 32'(bcd_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
